// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
//   Produces the instruction-memory fetch address with a post-reset boot
//   delay, stall hold, buffered branch/jump redirect with alignment
//   checking, and an optional trap vector (enabled by `define PC_TRAP_EN).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i             pipeline stall, holds the PC
//   fetch_ready_i       instruction memory accepts an address this cycle
//   br_valid_i          one-cycle redirect request
//   br_target_i         redirect target address
//   trap_valid_i        trap request            (PC_TRAP_EN only)
//   trap_vec_i          trap handler address    (PC_TRAP_EN only)
//   pc_o                current fetch address
//   ce_o                instruction memory chip enable
//   pc_valid_o          pc_o is a valid fetch request
//   misalign_o          pulse: a captured target had its low bits forced to 0
module pc_gen #(
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned            STEP         = 4,
   parameter int unsigned            BOOT_CYCLES  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_i,
   input  logic                  fetch_ready_i,
   input  logic                  br_valid_i,
   input  logic [ADDR_WIDTH-1:0] br_target_i,
`ifdef PC_TRAP_EN
   input  logic                  trap_valid_i,
   input  logic [ADDR_WIDTH-1:0] trap_vec_i,
`endif
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  ce_o,
   output logic                  pc_valid_o,
   output logic                  misalign_o
);

   localparam int unsigned           CNT_W      = 4;
   localparam logic [CNT_W-1:0]      BOOT_INIT  = CNT_W'(BOOT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] STEP_ADDR  = ADDR_WIDTH'(STEP);
   // Low bits that must be zero in any target (log2(STEP) bits).
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STEP - 1);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STALL} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        boot_cnt;
   logic                    pend_flag;
   logic [ADDR_WIDTH-1:0]   pend_addr;

   logic [ADDR_WIDTH-1:0]   br_tgt;
   logic                    br_mis;
   logic                    trap_req;
   logic                    trap_take;
   logic [ADDR_WIDTH-1:0]   trap_pc;
   logic                    trap_mis;

   assign br_tgt = br_target_i & ~ALIGN_MASK;
   assign br_mis = |(br_target_i & ALIGN_MASK);

`ifdef PC_TRAP_EN
   logic                  trap_pend;
   logic [ADDR_WIDTH-1:0] trap_addr;
   logic [ADDR_WIDTH-1:0] trap_tgt;

   assign trap_tgt  = trap_vec_i & ~ALIGN_MASK;
   assign trap_req  = trap_valid_i;
   // A trap seen during BOOT waits until boot completes; a fresh one wins.
   assign trap_take = (trap_valid_i | trap_pend) & (state != ST_BOOT);
   assign trap_pc   = trap_valid_i ? trap_tgt : trap_addr;
   assign trap_mis  = trap_valid_i & (|(trap_vec_i & ALIGN_MASK));

   // Trap hold register for requests arriving during BOOT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_pend <= 1'b0;
         trap_addr <= '0;
      end else if (trap_take) begin
         trap_pend <= 1'b0;
      end else if (trap_valid_i) begin
         trap_pend <= 1'b1;
         trap_addr <= trap_tgt;
      end
   end
`else
   assign trap_req  = 1'b0;
   assign trap_take = 1'b0;
   assign trap_pc   = '0;
   assign trap_mis  = 1'b0;
`endif

   // PC state machine; a trap request suppresses any same-cycle redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_BOOT;
         boot_cnt   <= BOOT_INIT;
         pend_flag  <= 1'b0;
         pend_addr  <= '0;
         pc_o       <= RESET_VECTOR;
         ce_o       <= 1'b0;
         pc_valid_o <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         misalign_o <= trap_mis | (br_valid_i & br_mis & ~trap_req);
         if (trap_take) begin
            state      <= ST_RUN;
            pc_o       <= trap_pc;
            ce_o       <= 1'b1;
            pc_valid_o <= 1'b1;
            pend_flag  <= 1'b0;
         end else begin
            case (state)
               ST_BOOT: begin
                  boot_cnt <= boot_cnt - CNT_W'(1);
                  if (boot_cnt == CNT_W'(1)) begin
                     state      <= ST_RUN;
                     ce_o       <= 1'b1;
                     pc_valid_o <= 1'b1;
                  end
                  if (br_valid_i && !trap_req) begin
                     pend_flag <= 1'b1;
                     pend_addr <= br_tgt;
                  end
               end
               ST_STALL: begin
                  if (!stall_i) begin
                     state      <= ST_RUN;
                     pc_valid_o <= 1'b1;
                  end
                  if (br_valid_i) begin
                     pend_flag <= 1'b1;
                     pend_addr <= br_tgt;
                  end
               end
               default: begin
                  if (stall_i) begin
                     state      <= ST_STALL;
                     pc_valid_o <= 1'b0;
                     if (br_valid_i) begin
                        pend_flag <= 1'b1;
                        pend_addr <= br_tgt;
                     end
                  end else if (br_valid_i) begin
                     // Newest redirect replaces any buffered one.
                     pc_o      <= br_tgt;
                     pend_flag <= 1'b0;
                  end else if (pend_flag) begin
                     pc_o      <= pend_addr;
                     pend_flag <= 1'b0;
                  end else if (pc_valid_o && fetch_ready_i) begin
                     pc_o <= pc_o + STEP_ADDR;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized self-checking bench for pc_gen against a
// behavioural reference model; also checks address wrap on an 8-bit build.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        ready;
   logic        br;
   logic [31:0] tgt;

   logic [31:0] pc;
   logic        ce;
   logic        valid;
   logic        mis;

   logic [7:0]  w_pc;
   logic        w_ce;
   logic        w_valid;
   logic        w_mis;

`ifdef PC_TRAP_EN
   logic        trap_valid = 1'b0;
   logic [31:0] trap_vec   = '0;
   logic [7:0]  w_trap_vec = '0;
`endif

   always #5 clk = ~clk;

   pc_gen u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall),
      .fetch_ready_i (ready),
      .br_valid_i    (br),
      .br_target_i   (tgt),
`ifdef PC_TRAP_EN
      .trap_valid_i  (trap_valid),
      .trap_vec_i    (trap_vec),
`endif
      .pc_o          (pc),
      .ce_o          (ce),
      .pc_valid_o    (valid),
      .misalign_o    (mis)
   );

   pc_gen #(
      .ADDR_WIDTH   (8),
      .RESET_VECTOR (8'hF8),
      .STEP         (4),
      .BOOT_CYCLES  (1)
   ) u_wrap (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (1'b0),
      .fetch_ready_i (1'b1),
      .br_valid_i    (1'b0),
      .br_target_i   (8'h00),
`ifdef PC_TRAP_EN
      .trap_valid_i  (1'b0),
      .trap_vec_i    (w_trap_vec),
`endif
      .pc_o          (w_pc),
      .ce_o          (w_ce),
      .pc_valid_o    (w_valid),
      .misalign_o    (w_mis)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: cycle-level behaviour from the fetch rules.
   int unsigned m_pc;
   int          m_boot;
   bit          m_stalled;
   bit          m_ce;
   bit          m_valid;
   bit          m_mis;
   int unsigned pend[$];

   localparam int unsigned M_STEP = 4;

   function automatic void model_reset();
      m_pc      = 0;
      m_boot    = 1;
      m_stalled = 0;
      m_ce      = 0;
      m_valid   = 0;
      m_mis     = 0;
      pend.delete();
   endfunction

   function automatic void model_edge();
      int unsigned t;
      t     = tgt - (tgt % M_STEP);
      m_mis = br && (tgt % M_STEP != 0);
      if (m_boot > 0) begin
         if (br) pend = '{t};
         m_boot--;
         if (m_boot == 0) begin
            m_ce    = 1;
            m_valid = 1;
         end
      end else if (m_stalled) begin
         if (br) pend = '{t};
         if (!stall) begin
            m_stalled = 0;
            m_valid   = 1;
         end
      end else if (stall) begin
         if (br) pend = '{t};
         m_stalled = 1;
         m_valid   = 0;
      end else if (br) begin
         m_pc = t;
         pend.delete();
      end else if (pend.size() > 0) begin
         m_pc = pend[pend.size()-1];
         pend.delete();
      end else if (ready) begin
         m_pc = 32'((64'(m_pc) + 64'(M_STEP)) % 64'h1_0000_0000);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("pc", pc, m_pc);
      check("ce", 32'(ce), 32'(m_ce));
      check("valid", 32'(valid), 32'(m_valid));
      check("mis", 32'(mis), 32'(m_mis));
   endtask

   task automatic rand_inputs();
      stall = ($urandom % 4) == 0;
      ready = ($urandom % 4) != 0;
      br    = ($urandom % 10) == 0;
      tgt   = $urandom;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      ready = 1'b1;
      br    = 1'b0;
      tgt   = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_ce", 32'(ce), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_mis", 32'(mis), 32'h0);
      check("wrap_rst_pc", 32'(w_pc), 32'hF8);
      check("wrap_rst_ce", 32'(w_ce), 32'h0);

      rst_n = 1'b1;
      step();
      check("boot_pc0", pc, 32'h0);
      check("boot_valid", 32'(valid), 32'h1);
      check("wrap_pc0", 32'(w_pc), 32'hF8);
      step();
      check("run_pc4", pc, 32'h4);
      check("wrap_pc1", 32'(w_pc), 32'hFC);
      step();
      check("run_pc8", pc, 32'h8);
      check("wrap_pc2", 32'(w_pc), 32'h00);
      check("wrap_valid", 32'(w_valid), 32'h1);
      step();
      step();
      check("pc_10", pc, 32'h10);

      // Stall for three cycles with a redirect arriving mid-stall.
      stall = 1'b1;
      step();
      check("stall_pc", pc, 32'h10);
      check("stall_valid", 32'(valid), 32'h0);
      br = 1'b1; tgt = 32'h200;
      step();
      br = 1'b0;
      step();
      check("stall_pc3", pc, 32'h10);
      stall = 1'b0;
      step();
      step();
      check("redir_200", pc, 32'h200);
      step();
      check("redir_204", pc, 32'h204);

      // Two redirects while stalled: latest wins.
      stall = 1'b1;
      step();
      br = 1'b1; tgt = 32'h100;
      step();
      tgt = 32'h300;
      step();
      br = 1'b0; stall = 1'b0;
      step();
      step();
      check("latest_300", pc, 32'h300);

      // Misaligned target is forced aligned and flagged for one cycle.
      br = 1'b1; tgt = 32'h1003;
      step();
      check("align_1000", pc, 32'h1000);
      check("mis_pulse", 32'(mis), 32'h1);
      br = 1'b0;
      step();
      check("mis_clear", 32'(mis), 32'h0);
      check("after_1004", pc, 32'h1004);

      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         step();
      end

      // Asynchronous reset mid-stream, away from any clock edge.
      stall = 1'b0; br = 1'b0; ready = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_ce", 32'(ce), 32'h0);
      check("async_rst_valid", 32'(valid), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rand_inputs();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
